// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths and the stage-boundary
// register layouts used by EX, MEM and WB.
package cpu_pkg;

  localparam int BITS                = 32;
  localparam int REG_INDEX_BIT_WIDTH = 4;
  localparam int ADDR_ALIGN_BITS     = 2;

  typedef struct packed {
    logic                           valid;
    logic                           isLoad;
    logic                           isStore;
    logic                           regWrEn;
    logic [REG_INDEX_BIT_WIDTH-1:0] destReg;
    logic [BITS-1:0]                addr;
    logic [BITS-1:0]                storeData;
  } ex_mem_t;

  typedef struct packed {
    logic                           valid;
    logic                           regWrEn;
    logic                           misaligned;
    logic [REG_INDEX_BIT_WIDTH-1:0] destReg;
    logic [BITS-1:0]                data;
  } mem_wb_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: reset and flush clear it to zero, hold keeps it.
// Priority is reset > hold > flush > load.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (hold)       q_d = q_q;
    else if (flush) q_d = '0;
    else            q_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mem_stage.sv
// CPU memory stage: EX/MEM register, shared data-bus drive with single-shot
// stores under stall, forwarding to EX, and the MEM/WB register.
module mem_stage #(
  parameter int BITS                = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int ADDR_ALIGN_BITS     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           ex_valid,
  input  logic                           ex_isLoad,
  input  logic                           ex_isStore,
  input  logic                           ex_regWrEn,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_destReg,
  input  logic [BITS-1:0]                ex_aluResult,
  input  logic [BITS-1:0]                ex_storeData,
  output logic [BITS-1:0]                busAddr,
  output logic                           busWe,
  output logic [BITS-1:0]                busWrData,
  input  logic [BITS-1:0]                busRdData,
  output logic                           fwd_valid,
  output logic [REG_INDEX_BIT_WIDTH-1:0] fwd_reg,
  output logic [BITS-1:0]                fwd_data,
  output logic                           wb_valid,
  output logic                           wb_regWrEn,
  output logic [REG_INDEX_BIT_WIDTH-1:0] wb_destReg,
  output logic [BITS-1:0]                wb_data,
  output logic                           wb_misaligned
);

  import cpu_pkg::*;

  ex_mem_t ex_d;
  ex_mem_t m_q;
  mem_wb_t wb_d;
  mem_wb_t wb_q;
  logic    storeDone_q;
  logic    storeDone_d;
  logic    aligned;
  logic    misaligned;

  always_comb begin
    ex_d           = '0;
    ex_d.valid     = ex_valid;
    ex_d.isLoad    = ex_isLoad;
    ex_d.isStore   = ex_isStore;
    ex_d.regWrEn   = ex_regWrEn;
    ex_d.destReg   = ex_destReg;
    ex_d.addr      = ex_aluResult;
    ex_d.storeData = ex_storeData;
  end

  pipe_reg #(.W($bits(ex_mem_t))) u_ex_mem (
    .clk   (clk),
    .reset (reset),
    .hold  (stall),
    .flush (flush),
    .d     (ex_d),
    .q     (m_q)
  );

  assign aligned    = (m_q.addr[ADDR_ALIGN_BITS-1:0] == '0);
  assign misaligned = m_q.valid & (m_q.isLoad | m_q.isStore) & ~aligned;

  assign busAddr   = m_q.valid ? m_q.addr : '0;
  assign busWe     = m_q.valid & m_q.isStore & aligned & ~storeDone_q;
  assign busWrData = busWe ? m_q.storeData : '0;

  // A store held by stall must reach side-effecting devices only once.
  always_comb begin
    storeDone_d = storeDone_q;
    if (!stall)     storeDone_d = 1'b0;
    else if (busWe) storeDone_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) storeDone_q <= 1'b0;
    else       storeDone_q <= storeDone_d;
  end

  assign fwd_valid = m_q.valid & m_q.regWrEn & ~(m_q.isLoad & ~aligned);
  assign fwd_reg   = m_q.destReg;
  assign fwd_data  = m_q.isLoad ? busRdData : m_q.addr;

  always_comb begin
    wb_d            = '0;
    wb_d.valid      = m_q.valid;
    wb_d.destReg    = m_q.destReg;
    wb_d.misaligned = misaligned;
    wb_d.regWrEn    = m_q.valid & m_q.regWrEn & ~misaligned;
    if (m_q.isLoad & misaligned) wb_d.data = '0;
    else if (m_q.isLoad)         wb_d.data = busRdData;
    else                         wb_d.data = m_q.addr;
  end

  // Stall drains a bubble into WB while EX/MEM holds its instruction.
  pipe_reg #(.W($bits(mem_wb_t))) u_mem_wb (
    .clk   (clk),
    .reset (reset),
    .hold  (1'b0),
    .flush (stall),
    .d     (wb_d),
    .q     (wb_q)
  );

  assign wb_valid      = wb_q.valid;
  assign wb_regWrEn    = wb_q.regWrEn;
  assign wb_destReg    = wb_q.destReg;
  assign wb_data       = wb_q.data;
  assign wb_misaligned = wb_q.misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a small word memory on the data bus
// covering addresses 0x00-0xFF; other addresses read back as 0.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        ex_valid, ex_isLoad, ex_isStore, ex_regWrEn;
  logic [3:0]  ex_destReg;
  logic [31:0] ex_aluResult, ex_storeData;
  logic [31:0] busAddr, busWrData, busRdData;
  logic        busWe;
  logic        fwd_valid;
  logic [3:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        wb_valid, wb_regWrEn, wb_misaligned;
  logic [3:0]  wb_destReg;
  logic [31:0] wb_data;

  logic [31:0] mem [0:63];
  int          wr_count;
  int          vectors = 0;
  int          errors  = 0;
  int          cnt0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_isLoad(ex_isLoad), .ex_isStore(ex_isStore),
    .ex_regWrEn(ex_regWrEn), .ex_destReg(ex_destReg),
    .ex_aluResult(ex_aluResult), .ex_storeData(ex_storeData),
    .busAddr(busAddr), .busWe(busWe), .busWrData(busWrData), .busRdData(busRdData),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_regWrEn(wb_regWrEn), .wb_destReg(wb_destReg),
    .wb_data(wb_data), .wb_misaligned(wb_misaligned)
  );

  assign busRdData = (busAddr < 32'h100) ? mem[busAddr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      wr_count <= 0;
    end else if (busWe) begin
      if (busAddr < 32'h100) mem[busAddr[7:2]] <= busWrData;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic rw,
                       input logic [3:0] dst, input logic [31:0] alu, input logic [31:0] sd);
    ex_valid = v; ex_isLoad = ld; ex_isStore = st; ex_regWrEn = rw;
    ex_destReg = dst; ex_aluResult = alu; ex_storeData = sd;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 32'h40, 32'h1111_2222);
    tick(); tick();
    vectors++; if (busWe !== 1'b0) begin errors++; $display("FAIL reset_busWe got=%b exp=0", busWe); end
    vectors++; if (busAddr !== 32'h0 || busWrData !== 32'h0) begin errors++; $display("FAIL reset_bus got addr=%h wd=%h exp=0", busAddr, busWrData); end
    vectors++; if (fwd_valid !== 1'b0 || fwd_reg !== 4'd0 || fwd_data !== 32'h0) begin errors++; $display("FAIL reset_fwd got v=%b r=%0d d=%h exp=0", fwd_valid, fwd_reg, fwd_data); end
    vectors++; if (wb_valid !== 1'b0 || wb_regWrEn !== 1'b0 || wb_misaligned !== 1'b0 || wb_destReg !== 4'd0 || wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb got v=%b we=%b mis=%b r=%0d d=%h exp=0", wb_valid, wb_regWrEn, wb_misaligned, wb_destReg, wb_data); end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    cnt0 = wr_count;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h10, 32'hDEAD_BEEF);
    tick();
    vectors++; if (busWe !== 1'b1 || busAddr !== 32'h10 || busWrData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_bus got we=%b addr=%h wd=%h exp we=1 addr=10 wd=deadbeef", busWe, busAddr, busWrData); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h10, 32'h0);
    tick();
    vectors++; if (busWe !== 1'b0) begin errors++; $display("FAIL load_busWe got=%b exp=0", busWe); end
    vectors++; if (fwd_valid !== 1'b1 || fwd_reg !== 4'd3 || fwd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_fwd got v=%b r=%0d d=%h exp v=1 r=3 d=deadbeef", fwd_valid, fwd_reg, fwd_data); end
    vectors++; if (wb_valid !== 1'b1 || wb_regWrEn !== 1'b0 || wb_misaligned !== 1'b0) begin errors++; $display("FAIL store_wb got v=%b we=%b mis=%b exp v=1 we=0 mis=0", wb_valid, wb_regWrEn, wb_misaligned); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    tick();
    vectors++; if (wb_valid !== 1'b1 || wb_regWrEn !== 1'b1 || wb_destReg !== 4'd3 || wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_wb got v=%b we=%b r=%0d d=%h exp v=1 we=1 r=3 d=deadbeef", wb_valid, wb_regWrEn, wb_destReg, wb_data); end
    vectors++; if (wr_count - cnt0 !== 1) begin errors++; $display("FAIL store_writes got=%0d exp=1", wr_count - cnt0); end
  endtask

  task automatic test_stalled_store();
    cnt0 = wr_count;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h20, 32'hCAFE_F00D);
    tick();
    vectors++; if (busWe !== 1'b1 || busAddr !== 32'h20) begin errors++; $display("FAIL stall_first got we=%b addr=%h exp we=1 addr=20", busWe, busAddr); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (busWe !== 1'b0 || wb_valid !== 1'b0 || busAddr !== 32'h20) begin errors++; $display("FAIL stall_hold%0d got we=%b wbv=%b addr=%h exp we=0 wbv=0 addr=20", i, busWe, wb_valid, busAddr); end
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    tick();
    vectors++; if (wb_valid !== 1'b1 || wb_regWrEn !== 1'b0) begin errors++; $display("FAIL stall_release got wbv=%b we=%b exp wbv=1 we=0", wb_valid, wb_regWrEn); end
    vectors++; if (wr_count - cnt0 !== 1) begin errors++; $display("FAIL stall_writes got=%0d exp=1", wr_count - cnt0); end
    vectors++; if (mem[8] !== 32'hCAFE_F00D) begin errors++; $display("FAIL stall_memdata got=%h exp=cafef00d", mem[8]); end
  endtask

  task automatic test_misaligned();
    cnt0 = wr_count;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 32'h13, 32'h0);
    tick();
    vectors++; if (fwd_valid !== 1'b0 || busWe !== 1'b0 || busAddr !== 32'h13) begin errors++; $display("FAIL mis_load_mem got fv=%b we=%b addr=%h exp fv=0 we=0 addr=13", fwd_valid, busWe, busAddr); end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h22, 32'h5555_5555);
    tick();
    vectors++; if (busWe !== 1'b0) begin errors++; $display("FAIL mis_store_we got=%b exp=0", busWe); end
    vectors++; if (wb_valid !== 1'b1 || wb_misaligned !== 1'b1 || wb_regWrEn !== 1'b0 || wb_data !== 32'h0 || wb_destReg !== 4'd5) begin errors++; $display("FAIL mis_load_wb got v=%b mis=%b we=%b d=%h r=%0d exp v=1 mis=1 we=0 d=0 r=5", wb_valid, wb_misaligned, wb_regWrEn, wb_data, wb_destReg); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    tick();
    vectors++; if (wb_misaligned !== 1'b1 || wb_regWrEn !== 1'b0 || busWe !== 1'b0) begin errors++; $display("FAIL mis_store_wb got mis=%b we=%b bwe=%b exp mis=1 we=0 bwe=0", wb_misaligned, wb_regWrEn, busWe); end
    vectors++; if (wr_count - cnt0 !== 0) begin errors++; $display("FAIL mis_writes got=%0d exp=0", wr_count - cnt0); end
  endtask

  task automatic test_flush();
    cnt0 = wr_count;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h30, 32'h0000_0001);
    flush = 1'b1;
    tick();
    vectors++; if (busWe !== 1'b0 || busAddr !== 32'h0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL flush_mem got we=%b addr=%h fv=%b exp 0", busWe, busAddr, fwd_valid); end
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    tick();
    vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb got=%b exp=0", wb_valid); end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h34, 32'h0000_0077);
    tick();
    vectors++; if (busWe !== 1'b1 || busAddr !== 32'h34) begin errors++; $display("FAIL fs_first got we=%b addr=%h exp we=1 addr=34", busWe, busAddr); end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h38, 32'h0000_0099);
    stall = 1'b1; flush = 1'b1;
    tick();
    vectors++; if (busWe !== 1'b0 || busAddr !== 32'h34 || wb_valid !== 1'b0) begin errors++; $display("FAIL fs_hold got we=%b addr=%h wbv=%b exp we=0 addr=34 wbv=0", busWe, busAddr, wb_valid); end
    stall = 1'b0;
    tick();
    flush = 1'b0;
    vectors++; if (busAddr !== 32'h0 || busWe !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL fs_release got addr=%h we=%b wbv=%b exp addr=0 we=0 wbv=1", busAddr, busWe, wb_valid); end
    vectors++; if (wr_count - cnt0 !== 1 || mem[13] !== 32'h0000_0077) begin errors++; $display("FAIL fs_writes got n=%0d m=%h exp n=1 m=77", wr_count - cnt0, mem[13]); end
  endtask

  task automatic test_alu_passthru();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 32'h1234, 32'hFFFF_FFFF);
    tick();
    vectors++; if (fwd_valid !== 1'b1 || fwd_reg !== 4'd7 || fwd_data !== 32'h1234 || busWe !== 1'b0 || busWrData !== 32'h0) begin errors++; $display("FAIL alu_fwd got v=%b r=%0d d=%h we=%b wd=%h exp v=1 r=7 d=1234 we=0 wd=0", fwd_valid, fwd_reg, fwd_data, busWe, busWrData); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h400, 32'h0);
    tick();
    vectors++; if (wb_valid !== 1'b1 || wb_regWrEn !== 1'b1 || wb_destReg !== 4'd7 || wb_data !== 32'h1234) begin errors++; $display("FAIL alu_wb got v=%b we=%b r=%0d d=%h exp v=1 we=1 r=7 d=1234", wb_valid, wb_regWrEn, wb_destReg, wb_data); end
    vectors++; if (fwd_valid !== 1'b1 || fwd_data !== 32'h0) begin errors++; $display("FAIL unmapped_fwd got v=%b d=%h exp v=1 d=0", fwd_valid, fwd_data); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    tick();
    vectors++; if (wb_regWrEn !== 1'b1 || wb_destReg !== 4'd2 || wb_data !== 32'h0 || wb_misaligned !== 1'b0) begin errors++; $display("FAIL unmapped_wb got we=%b r=%0d d=%h mis=%b exp we=1 r=2 d=0 mis=0", wb_regWrEn, wb_destReg, wb_data, wb_misaligned); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_stalled_store();
    test_misaligned();
    test_flush();
    test_alu_passthru();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory stage of the CPU.
- Holds the EX/MEM pipeline register and drives the shared data bus (address, write enable, write data) that feeds the data memory and the other memory-mapped devices.
- Captures the OR-combined bus read data into the MEM/WB pipeline register.
- Provides forwarding data to EX, and enforces alignment and single-issue stores under stall.

Parameters:
- BITS, 32, data/address width.
- REG_INDEX_BIT_WIDTH, 4, register index width.
- ADDR_ALIGN_BITS, 2, low address bits that must be zero for a legal access.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hold EX/MEM contents; bubble into MEM/WB
- flush  in  1  insert bubble into EX/MEM
- ex_valid  in  1  EX instruction valid
- ex_isLoad  in  1  load instruction
- ex_isStore  in  1  store instruction
- ex_regWrEn  in  1  writes a register
- ex_destReg  in  REG_INDEX_BIT_WIDTH  destination register
- ex_aluResult  in  BITS  ALU result / effective address
- ex_storeData  in  BITS  store data
- busAddr  out  BITS  bus address to devices
- busWe  out  1  bus write strobe; devices write at the clk edge while high
- busWrData  out  BITS  bus write data
- busRdData  in  BITS  OR of device outputs; 0 when no device is selected
- fwd_valid  out  1  MEM-stage result forwardable
- fwd_reg  out  REG_INDEX_BIT_WIDTH  MEM-stage destination
- fwd_data  out  BITS  MEM-stage result
- wb_valid  out  1  WB instruction valid
- wb_regWrEn  out  1  register write enable
- wb_destReg  out  REG_INDEX_BIT_WIDTH  WB destination
- wb_data  out  BITS  WB result
- wb_misaligned  out  1  WB instruction had a misaligned access

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high. Priority at each clk edge: reset > stall > flush > normal. A flush during stall is ignored; the source keeps flush asserted until stall drops.
- Reset: all registered state, including storeDone, clears to 0. All outputs are therefore 0.
- EX/MEM register fields: m_valid, m_isLoad, m_isStore, m_regWrEn, m_destReg, m_addr, m_storeData.
  - stall: hold all fields.
  - flush: m_valid=0; other fields don't-care, but the control bits must also clear.
  - normal: capture the ex_* inputs.
- Alignment: aligned = (m_addr[ADDR_ALIGN_BITS-1:0] == 0).
- Bus drive (combinational from the EX/MEM register):
  - busAddr = m_addr whenever m_valid, else 0.
  - busWe = m_valid & m_isStore & aligned & !storeDone.
  - busWrData = busWe ? m_storeData : 0.
- storeDone:
  - Set at a clk edge with busWe=1 and stall=1.
  - Cleared at any edge where EX/MEM advances (not stalled), and on reset.
  - Result: a stalled store writes exactly once, which matters for side-effecting devices.
- Forwarding (combinational):
  - fwd_valid = m_valid & m_regWrEn & !(m_isLoad & !aligned).
  - fwd_reg = m_destReg.
  - fwd_data = m_isLoad ? busRdData : m_addr.
- MEM/WB register:
  - stall: bubble (wb_valid=0, wb_regWrEn=0, wb_misaligned=0, wb_data=0).
  - Otherwise:
    - wb_valid = m_valid.
    - wb_destReg = m_destReg.
    - wb_misaligned = m_valid & (m_isLoad|m_isStore) & !aligned.
    - wb_regWrEn = m_valid & m_regWrEn & !wb_misaligned.
    - wb_data = misaligned load ? 0 : (m_isLoad ? busRdData : m_addr).
- Misaligned store: no bus write; instruction retires with wb_misaligned=1.
- Latency:
  - ex_* to bus outputs: 1 cycle.
  - Bus to wb_*: +1 cycle.
  - A store is visible in memory at the edge ending its MEM cycle.
  - A load issued in cycle N is readable by the next instruction via forwarding in cycle N.
- Unmapped address: busRdData=0 is captured unchanged; no error is raised.
- Load and store both set: treated as a store for busWe and as a load for data; upstream must never produce this.

Decomposition:
- Shared package (cpu_pkg):
  - BITS and REG_INDEX_BIT_WIDTH constants.
  - ADDR_ALIGN_BITS.
  - The EX/MEM and MEM/WB struct typedefs, reused by the EX and WB stages.
- Sub-module pipe_reg: a parameterised width register with reset/stall/flush, instantiated twice (EX/MEM and MEM/WB).
  - MEM/WB ties stall→bubble via its flush input, with its hold input grounded.

Test Plan:
1. Reset: assert reset for 2 cycles with ex_valid=1 -> every output 0, including busWe and wb_valid.
2. Aligned store then load: store addr 0x10, data 0xDEADBEEF -> busWe=1 for exactly one cycle with busAddr=0x10. Next, load 0x10 to r3 with busRdData model returning 0xDEADBEEF -> fwd_data=0xDEADBEEF in MEM, and one cycle later wb_regWrEn=1, wb_destReg=3, wb_data=0xDEADBEEF.
3. Stalled store: store 0x20 held by stall for 3 cycles -> busWe high in the first cycle only; exactly one write counted; wb_valid=0 during the stall, then 1 after release.
4. Misaligned: load 0x13 to r5 -> wb_misaligned=1, wb_regWrEn=0, wb_data=0, fwd_valid=0. Store 0x22 -> busWe never asserts.
5. Flush vs stall: flush alone -> next-cycle busWe=0 and wb_valid=0 one cycle later. Flush+stall together -> EX/MEM held and its store still issued once.
6. ALU pass-through: non-memory op, aluResult 0x1234 to r7 -> fwd_data=0x1234, busWe=0, then wb_data=0x1234, wb_regWrEn=1.
